// File: rtl/fifo_wr_ptr_ctrl_if.sv
// Write-side bus of the async FIFO pointer controller.
// The master drives push requests and the read-domain pointer; the slave answers.
interface fifo_wr_ptr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wrReq;
  logic [ADDR_WIDTH:0]   rdPtrGray;
  logic                  wrEn;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [ADDR_WIDTH:0]   wrPtrGray;
  logic                  full;
  logic                  almostFull;
  logic [ADDR_WIDTH:0]   wrCount;

  modport master (
    output wrReq, rdPtrGray,
    input  wrEn, wrAddr, wrPtrGray,
    input  full, almostFull, wrCount
  );

  modport slave (
    input  wrReq, rdPtrGray,
    output wrEn, wrAddr, wrPtrGray,
    output full, almostFull, wrCount
  );
endinterface

// File: rtl/fifo_wr_ptr_ctrl.sv
// Async FIFO write-side pointer controller: binary/Gray write pointer,
// read-pointer synchronizer and pessimistic full/almost-full/fill status.
module fifo_wr_ptr_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 2**ADDR_WIDTH - 2
) (
  input logic              ACLK,
  input logic              sysReset,
  fifo_wr_ptr_ctrl_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_gray;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rd_sync [SYNC_STAGES];
  logic [PW-1:0] rd_s;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] fill_next;
  logic [PW-1:0] full_ptr;
  logic [PW-1:0] cnt_q;
  logic          full_q;
  logic          af_q;
  logic          wr_en;

  assign wr_en     = bus.wrReq & ~full_q;
  assign bin_next  = wr_bin + {{ADDR_WIDTH{1'b0}}, wr_en};
  assign gray_next = bin_next ^ (bin_next >> 1);
  assign rd_s      = rd_sync[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < PW; i++) begin
      rd_bin[i] = ^(rd_s >> i);
    end
  end

  assign fill_next = bin_next - rd_bin;
  assign full_ptr  = {~rd_s[ADDR_WIDTH:ADDR_WIDTH-1],
                      rd_s[ADDR_WIDTH-2:0]};

  always_ff @(posedge ACLK or posedge sysReset) begin
    if (sysReset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        rd_sync[k] <= '0;
      end
    end else begin
      rd_sync[0] <= bus.rdPtrGray;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        rd_sync[k] <= rd_sync[k-1];
      end
    end
  end

  always_ff @(posedge ACLK or posedge sysReset) begin
    if (sysReset) begin
      wr_bin  <= '0;
      wr_gray <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wr_bin  <= bin_next;
      wr_gray <= gray_next;
      full_q  <= (gray_next == full_ptr);
      af_q    <= (fill_next >= PW'(AF_THRESH));
      cnt_q   <= fill_next;
    end
  end

  assign bus.wrEn       = wr_en;
  assign bus.wrAddr     = wr_bin[ADDR_WIDTH-1:0];
  assign bus.wrPtrGray  = wr_gray;
  assign bus.full       = full_q;
  assign bus.almostFull = af_q;
  assign bus.wrCount    = cnt_q;
endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Directed bench for fifo_wr_ptr_ctrl: reset, fill, release,
// coincident full-clear, wrap with a trailing reader, and a random run.
module tb_fifo_wr_ptr_ctrl;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fifo_wr_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wr_ptr_ctrl #(.ADDR_WIDTH(AW)) dut (
    .ACLK     (clk),
    .sysReset (rst),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] g(input int b);
    logic [4:0] t;
    t = 5'(b);
    return t ^ (t >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gray"}, 32'(bus.wrPtrGray), 0);
    chk({tag, "_addr"}, 32'(bus.wrAddr), 0);
    chk({tag, "_cnt"}, 32'(bus.wrCount), 0);
    chk({tag, "_full"}, 32'(bus.full), 0);
    chk({tag, "_af"}, 32'(bus.almostFull), 0);
  endtask

  initial begin
    logic [4:0] prev;
    int mb, rb, s0, s1, mbn, fill;
    logic mfull, req, ewen;

    bus.wrReq     = 1'b0;
    bus.rdPtrGray = '0;
    #2;
    chk_idle("por");
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #3;

    // fill from empty with the reader parked at 0
    bus.wrReq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("fill_addr", 32'(bus.wrAddr), i);
      chk("fill_wen", 32'(bus.wrEn), 1);
      tick();
      chk("fill_cnt", 32'(bus.wrCount), i + 1);
      chk("fill_full", 32'(bus.full), (i == 15) ? 1 : 0);
      chk("fill_af", 32'(bus.almostFull), (i >= 13) ? 1 : 0);
      chk("fill_gray", 32'(bus.wrPtrGray), 32'(g(i + 1)));
    end
    #1;
    chk("over_wen", 32'(bus.wrEn), 0);
    tick();
    chk("over_gray", 32'(bus.wrPtrGray), 32'h18);
    chk("over_addr", 32'(bus.wrAddr), 0);
    chk("over_cnt", 32'(bus.wrCount), 16);
    chk("over_full", 32'(bus.full), 1);

    // one pop seen after three edges
    bus.wrReq     = 1'b0;
    bus.rdPtrGray = 5'b00001;
    tick();
    chk("rel_full_e1", 32'(bus.full), 1);
    tick();
    chk("rel_full_e2", 32'(bus.full), 1);
    chk("rel_cnt_e2", 32'(bus.wrCount), 16);
    tick();
    chk("rel_full_e3", 32'(bus.full), 0);
    chk("rel_cnt_e3", 32'(bus.wrCount), 15);
    chk("rel_af_e3", 32'(bus.almostFull), 1);
    bus.wrReq = 1'b1;
    #1;
    chk("rel_wen", 32'(bus.wrEn), 1);
    chk("rel_addr", 32'(bus.wrAddr), 0);
    tick();
    chk("refull", 32'(bus.full), 1);
    chk("refull_cnt", 32'(bus.wrCount), 16);
    chk("refull_gray", 32'(bus.wrPtrGray), 32'(g(17)));

    // full clears on the same edge that sees a request
    bus.rdPtrGray = g(2);
    for (int e = 0; e < 3; e++) begin
      #1;
      chk("sim_wen_blk", 32'(bus.wrEn), 0);
      tick();
    end
    chk("sim_full", 32'(bus.full), 0);
    chk("sim_cnt", 32'(bus.wrCount), 15);
    chk("sim_addr", 32'(bus.wrAddr), 1);
    #1;
    chk("sim_wen", 32'(bus.wrEn), 1);
    tick();
    chk("sim_full2", 32'(bus.full), 1);
    chk("sim_cnt2", 32'(bus.wrCount), 16);
    chk("sim_addr2", 32'(bus.wrAddr), 2);

    // asynchronous reset mid-cycle while requesting
    #3;
    rst = 1'b1;
    bus.rdPtrGray = '0;
    #1;
    chk_idle("arst");
    chk("arst_wen", 32'(bus.wrEn), 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("post_addr", 32'(bus.wrAddr), 0);
    chk("post_wen", 32'(bus.wrEn), 1);
    tick();
    chk("post_addr1", 32'(bus.wrAddr), 1);
    chk("post_cnt", 32'(bus.wrCount), 1);

    // wrap: reader trails the writer by four pushes
    bus.wrReq = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.wrReq = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.rdPtrGray = g((i > 4) ? i - 4 : 0);
      prev = bus.wrPtrGray;
      #1;
      chk("wrap_addr", 32'(bus.wrAddr), i % 16);
      tick();
      chk("wrap_full", 32'(bus.full), 0);
      chk("wrap_gray", 32'(bus.wrPtrGray), 32'(g(i + 1)));
      chk("wrap_hd", $countones(prev ^ bus.wrPtrGray), 1);
      chk("wrap_cnt", 32'(bus.wrCount), (i < 6) ? i + 1 : 7);
    end

    // random pushes against a randomly draining reader
    bus.wrReq = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    mb = 0; rb = 0; s0 = 0; s1 = 0; mfull = 1'b0;
    for (int c = 0; c < 120; c++) begin
      req = ($urandom_range(0, 3) != 0);
      if (rb != mb && $urandom_range(0, 2) == 0) rb = (rb + 1) & 31;
      bus.wrReq     = req;
      bus.rdPtrGray = g(rb);
      ewen = req & ~mfull;
      #1;
      chk("rnd_wen", 32'(bus.wrEn), 32'(ewen));
      tick();
      mbn   = (mb + int'(ewen)) & 31;
      fill  = (mbn - s1) & 31;
      mfull = (fill == 16);
      chk("rnd_full", 32'(bus.full), 32'(mfull));
      chk("rnd_cnt", 32'(bus.wrCount), fill);
      chk("rnd_af", 32'(bus.almostFull), (fill >= 14) ? 1 : 0);
      chk("rnd_bound", 32'(bus.wrCount <= 5'd16), 1);
      s1 = s0;
      s0 = rb;
      mb = mbn;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_ptr_ctrl.md
# fifo_wr_ptr_ctrl

Write-side pointer controller for the asynchronous FIFOs in the AXI4 convertor paths. It owns the binary write pointer and its registered Gray-coded copy for crossing into the read domain. It synchronizes the read side's Gray pointer into the write clock domain and derives full, almost-full and fill-level status. It gates pushes so the FIFO RAM is never overwritten.

## Interface
- ADDR_WIDTH, 4: RAM address width; depth = 2^ADDR_WIDTH; legal range ≥ 2.
- SYNC_STAGES, 2: flop stages on the incoming read pointer; legal range ≥ 2.
- AF_THRESH, 2^ADDR_WIDTH-2: almostFull asserts when fill level ≥ AF_THRESH.

- ACLK  in  1  write-domain clock; all state is updated on the rising edge.
- sysReset  in  1  asynchronous, active-high reset.
- wrReq  in  1  push request from the write-side master.
- rdPtrGray  in  ADDR_WIDTH+1  Gray-coded read pointer from the read domain; treated as asynchronous.
- wrEn  out  1  RAM write strobe.
- wrAddr  out  ADDR_WIDTH  RAM write address (binary).
- wrPtrGray  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- full  out  1  FIFO full; pushes are ignored while high.
- almostFull  out  1  fill level ≥ AF_THRESH.
- wrCount  out  ADDR_WIDTH+1  conservative fill level seen from the write side.

## Operation
- State:
  - wrPtrBin: ADDR_WIDTH+1 bits.
  - wrPtrGray register.
  - rdSync[SYNC_STAGES]: each ADDR_WIDTH+1 bits.
  - Registers for full, almostFull and wrCount.
- wrEn = wrReq & ~full. This is combinational and the only combinational output path.
- wrAddr = wrPtrBin[ADDR_WIDTH-1:0].
- wrPtrBinNext = wrPtrBin + wrEn, modulo 2^(ADDR_WIDTH+1). The pointer wraps naturally, with no special case.
- wrPtrGrayNext = wrPtrBinNext ^ (wrPtrBinNext >> 1). This is the standard binary-to-Gray rule: MSB passes through, bit i = b[i]^b[i+1].
- Synchronizer: rdSync[0] <= rdPtrGray and rdSync[k] <= rdSync[k-1]. Only rdSync[SYNC_STAGES-1] (rdS) is used.
  - No logic between rdPtrGray and rdSync[0].
- rdBinS = Gray-to-binary of rdS: bit MSB = g[MSB], bit i = b[i+1]^g[i].
- On each edge:
  - full <= (wrPtrGrayNext == {~rdS[ADDR_WIDTH:ADDR_WIDTH-1], rdS[ADDR_WIDTH-2:0]}).
  - wrCount <= wrPtrBinNext - rdBinS, modulo 2^(ADDR_WIDTH+1). The range is 0..2^ADDR_WIDTH.
  - almostFull <= (wrPtrBinNext - rdBinS) ≥ AF_THRESH.
- Status is pessimistic:
  - full and wrCount lag read-side pops by the synchronizer latency. Overflow is impossible.
  - full never lags this side's own pushes.
- Simultaneous events:
  - Push with full deasserting on the same edge: the push is rejected, because wrEn uses the current full.
  - A read-pointer move and a push on the same edge are both accounted for at the next status update.
- Reset (asynchronous, at any time including mid-burst): every register clears to 0.
  - Outputs: wrPtrGray=0, wrAddr=0, wrCount=0, full=0, almostFull=0.
  - wrEn = wrReq while in reset, but the RAM is held in reset by the same signal.
  - The read side is reset by the same sysReset. No pointer recovery is attempted.

## Timing
- Push acceptance: zero-cycle. wrEn is high in the cycle wrReq is sampled with full low, and the write occurs at that edge.
- After an accepted push, on the following edge:
  - wrAddr and wrPtrGray advance.
  - full, wrCount and almostFull reflect the push.
  - Sustained 1 push/cycle is supported until full.
- A change on rdPtrGray before edge k is visible in full, wrCount and almostFull after edge k+SYNC_STAGES. That is SYNC_STAGES+1 edges, or 3 at the default.
- wrPtrGray changes by exactly one bit per accepted push, including the 2^(ADDR_WIDTH+1)-1 → 0 wrap. It is driven directly from a register.

## Test plan
- Reset: assert sysReset asynchronously mid-cycle with wrReq=1 → all registered outputs go to 0 immediately, without waiting for an ACLK edge. After release, the first push writes wrAddr=0.
- Fill (ADDR_WIDTH=4, rdPtrGray=0):
  - 16 consecutive wrReq → wrAddr 0..15; full rises on the edge of the 16th push; wrCount=16; almostFull rose at wrCount=14.
  - A 17th wrReq gives wrEn=0 and wrPtrGray stays at 5'b11000.
- Release: from full, set rdPtrGray=5'b00001 → full falls and wrCount=15 exactly 3 edges later. The next push writes wrAddr=0 and full reasserts on its edge.
- Wrap: 40 pushes with rdPtrGray tracking the write pointer 4 cycles behind →
  - full never asserts.
  - wrAddr wraps 15→0 twice.
  - wrPtrGray steps 5'b10000→5'b00000 at bin 31→0.
  - Every wrPtrGray transition has Hamming distance 1.
- Simultaneous: the edge where synced full clears coincides with wrReq=1 → that push is rejected and the following cycle's push is accepted. wrCount is consistent with the reference model.
- Random: random wrReq and a randomly advancing legal rdPtrGray →
  - Scoreboard model matches wrCount/full/almostFull every cycle.
  - Accepted pushes never exceed 16 outstanding.
